lcd_writer: RTL and testbench

LCD_WRITER -- requirements
Module: lcd_writer

---
 rtl/lcd_writer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_lcd_writer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_writer.sv
// lcd_writer: HD44780 8-bit bus writer. Power-up delay, init sequence, then
// 18-byte two-line frames. Optional auto-refresh: `define LCD_AUTO_REFRESH_EN
// Ports: clk, rst_n (async low); start, out_x/out_y ("DD.F"), ball_x_lcd,
//        ball_y_lcd in; ready, done, lcd_rs, lcd_e, lcd_data out.
module lcd_writer #(
  parameter logic [23:0] POWERUP_CYC    = 24'd1_000_000,
  parameter logic [7:0]  E_HIGH_CYC     = 8'd24,
  parameter logic [15:0] CHAR_WAIT_CYC  = 16'd2_500,
  parameter logic [23:0] CLEAR_WAIT_CYC = 24'd100_000,
  parameter logic [23:0] REFRESH_CYC    = 24'd5_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] out_x,
  input  logic [31:0] out_y,
  input  logic [7:0]  ball_x_lcd,
  input  logic [7:0]  ball_y_lcd,
  output logic        ready,
  output logic        done,
  output logic        lcd_rs,
  output logic        lcd_e,
  output logic [7:0]  lcd_data
);

  typedef enum logic [1:0] {
    ST_PWR,
    ST_INIT,
    ST_IDLE,
    ST_FRAME
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_EHI,
    PH_WAIT
  } phase_t;

  localparam logic [23:0] PWR_LAST = POWERUP_CYC - 24'd1;
  localparam logic [23:0] EH_LAST  = {16'd0, E_HIGH_CYC} - 24'd1;
  localparam logic [23:0] CHR_LAST = {8'd0, CHAR_WAIT_CYC} - 24'd1;
  localparam logic [23:0] CLR_LAST = CLEAR_WAIT_CYC - 24'd1;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [23:0] cnt_q, cnt_d;
  logic [4:0]  idx_q, idx_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic [31:0] sx_q, sx_d;
  logic [31:0] sy_q, sy_d;
  logic [7:0]  bx_q, bx_d;
  logic [7:0]  by_q, by_d;

  logic        go;
  logic [23:0] wait_last;
  logic        byte_end;
  logic        last_byte;
  logic [8:0]  next_byte;

  function automatic logic [8:0] init_byte(
    input logic [4:0] i
  );
    logic [8:0] b;
    b = 9'h001;
    case (i)
      5'd0:    b = 9'h038;
      5'd1:    b = 9'h00C;
      5'd2:    b = 9'h006;
      default: b = 9'h001;
    endcase
    return b;
  endfunction

  // {rs, data} of frame byte i, line 1 then line 2
  function automatic logic [8:0] frame_byte(
    input logic [4:0]  i,
    input logic [31:0] sx,
    input logic [31:0] sy,
    input logic [7:0]  bx,
    input logic [7:0]  by
  );
    logic [8:0] b;
    b = 9'h080;
    case (i)
      5'd0:    b = 9'h080;
      5'd1:    b = {1'b1, 8'h58};
      5'd2:    b = {1'b1, 8'h3A};
      5'd3:    b = {1'b1, sx[31:24]};
      5'd4:    b = {1'b1, sx[23:16]};
      5'd5:    b = {1'b1, sx[15:8]};
      5'd6:    b = {1'b1, sx[7:0]};
      5'd7:    b = {1'b1, 8'h20};
      5'd8:    b = {1'b1, bx};
      5'd9:    b = 9'h0C0;
      5'd10:   b = {1'b1, 8'h59};
      5'd11:   b = {1'b1, 8'h3A};
      5'd12:   b = {1'b1, sy[31:24]};
      5'd13:   b = {1'b1, sy[23:16]};
      5'd14:   b = {1'b1, sy[15:8]};
      5'd15:   b = {1'b1, sy[7:0]};
      5'd16:   b = {1'b1, 8'h20};
      5'd17:   b = {1'b1, by};
      default: b = 9'h080;
    endcase
    return b;
  endfunction

`ifdef LCD_AUTO_REFRESH_EN
  localparam logic [23:0] REF_LAST = REFRESH_CYC - 24'd1;

  logic [23:0] ref_q, ref_d;
  logic        ref_hit;

  // Counts consecutive IDLE cycles; any frame start clears it
  always_comb begin
    ref_hit = (state_q == ST_IDLE) && (ref_q == REF_LAST);
    go      = start | ref_hit;
    ref_d   = 24'd0;
    if (state_q == ST_IDLE && !go) begin
      ref_d = ref_q + 24'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q <= 24'd0;
    end else begin
      ref_q <= ref_d;
    end
  end
`else
  always_comb begin
    go = start;
  end
`endif

  always_comb begin
    wait_last = CHR_LAST;
    if (!rs_q && data_q == 8'h01) begin
      wait_last = CLR_LAST;
    end
    byte_end = (phase_q == PH_WAIT) && (cnt_q == wait_last);
    if (state_q == ST_INIT) begin
      last_byte = (idx_q == 5'd3);
      next_byte = init_byte(idx_q + 5'd1);
    end else begin
      last_byte = (idx_q == 5'd17);
      next_byte = frame_byte(idx_q + 5'd1, sx_q, sy_q, bx_q, by_q);
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rs_d    = rs_q;
    data_d  = data_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    bx_d    = bx_q;
    by_d    = by_q;
    unique case (state_q)
      ST_PWR: begin
        if (cnt_q == PWR_LAST) begin
          state_d          = ST_INIT;
          phase_d          = PH_SETUP;
          cnt_d            = 24'd0;
          idx_d            = 5'd0;
          {rs_d, data_d}   = init_byte(5'd0);
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      ST_IDLE: begin
        if (go) begin
          state_d        = ST_FRAME;
          phase_d        = PH_SETUP;
          cnt_d          = 24'd0;
          idx_d          = 5'd0;
          {rs_d, data_d} = {1'b0, 8'h80};
          sx_d           = out_x;
          sy_d           = out_y;
          bx_d           = ball_x_lcd;
          by_d           = ball_y_lcd;
        end
      end
      ST_INIT, ST_FRAME: begin
        unique case (phase_q)
          PH_SETUP: begin
            phase_d = PH_EHI;
            cnt_d   = 24'd0;
          end
          PH_EHI: begin
            if (cnt_q == EH_LAST) begin
              phase_d = PH_WAIT;
              cnt_d   = 24'd0;
            end else begin
              cnt_d = cnt_q + 24'd1;
            end
          end
          PH_WAIT: begin
            if (byte_end) begin
              phase_d = PH_SETUP;
              cnt_d   = 24'd0;
              if (last_byte) begin
                state_d = ST_IDLE;
                idx_d   = 5'd0;
              end else begin
                idx_d          = idx_q + 5'd1;
                {rs_d, data_d} = next_byte;
              end
            end else begin
              cnt_d = cnt_q + 24'd1;
            end
          end
          default: begin
            phase_d = PH_SETUP;
            cnt_d   = 24'd0;
          end
        endcase
      end
      default: begin
        state_d = ST_PWR;
        cnt_d   = 24'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PWR;
      phase_q <= PH_SETUP;
      cnt_q   <= 24'd0;
      idx_q   <= 5'd0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      sx_q    <= 32'd0;
      sy_q    <= 32'd0;
      bx_q    <= 8'd0;
      by_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
    end
  end

  always_comb begin
    ready    = (state_q == ST_IDLE);
    done     = (state_q == ST_FRAME) && byte_end && (idx_q == 5'd17);
    lcd_e    = (state_q == ST_INIT || state_q == ST_FRAME)
               && (phase_q == PH_EHI);
    lcd_rs   = rs_q;
    lcd_data = data_q;
  end

endmodule

// File: tb/tb_lcd_writer.sv
// tb_lcd_writer: checks lcd_writer against a byte-schedule model
// plus directed literal expectations (init, frame, abort, refresh).
module tb_lcd_writer;

  localparam int P   = 10;
  localparam int EH  = 2;
  localparam int CW  = 4;
  localparam int CLW = 8;
  localparam int RF  = 50;
`ifdef LCD_AUTO_REFRESH_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] out_x = 32'd0;
  logic [31:0] out_y = 32'd0;
  logic [7:0]  bx = 8'd0;
  logic [7:0]  by = 8'd0;
  logic        ready, done, lcd_rs, lcd_e;
  logic [7:0]  lcd_data;

  lcd_writer #(
    .POWERUP_CYC(24'd10),
    .E_HIGH_CYC(8'd2),
    .CHAR_WAIT_CYC(16'd4),
    .CLEAR_WAIT_CYC(24'd8),
    .REFRESH_CYC(24'd50)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .out_x(out_x),
    .out_y(out_y),
    .ball_x_lcd(bx),
    .ball_y_lcd(by),
    .ready(ready),
    .done(done),
    .lcd_rs(lcd_rs),
    .lcd_e(lcd_e),
    .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_n = 0;
  int tot_n = 0;
  int fail_prints = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else begin
      if (fail_prints < 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                 nm, act, exp, cyc);
      fail_prints++;
    end
  endtask

  function automatic int wt(input logic [8:0] b);
    return (b[8] == 1'b0 && b[7:0] == 8'h01) ? CLW : CW;
  endfunction

  // model: a queue of bytes still to go on the bus
  int         m_mode = 0;   // 0 power-up, 1 sending, 2 idle
  int         m_pwr = 0;
  int         m_t = 0;
  int         m_idle = 0;
  bit         m_frame = 1'b0;
  logic [8:0] m_q[$];

  logic [8:0] cap_q[$];
  int         done_cnt = 0;
  bit         prev_e = 1'b0;

  always @(negedge clk) begin
    logic [8:0] cur;
    int dur;
    bit ee, ed, er;
    if (!rst_n) begin
      m_mode = 0; m_pwr = 0; m_t = 0; m_idle = 0;
      m_q.delete();
      chk("rst_e", lcd_e, 0);
      chk("rst_ready", ready, 0);
      chk("rst_done", done, 0);
      chk("rst_rs", lcd_rs, 0);
      chk("rst_data", lcd_data, 0);
      prev_e = 1'b0;
    end else begin
      ee = 1'b0; ed = 1'b0; er = (m_mode == 2);
      cur = 9'h000; dur = 1;
      if (m_mode == 1) begin
        cur = m_q[0];
        dur = 1 + EH + wt(cur);
        ee = (m_t >= 1 && m_t <= EH);
        ed = m_frame && m_q.size() == 1 && m_t == dur - 1;
        chk("m_rs", lcd_rs, cur[8]);
        chk("m_data", lcd_data, cur[7:0]);
      end
      chk("m_e", lcd_e, ee);
      chk("m_ready", ready, er);
      chk("m_done", done, ed);
      if (lcd_e && !prev_e) cap_q.push_back({lcd_rs, lcd_data});
      prev_e = lcd_e;
      if (done) done_cnt++;
      case (m_mode)
        0: begin
          m_pwr++;
          if (m_pwr == P) begin
            m_mode = 1; m_t = 0; m_frame = 1'b0;
            m_q = '{9'h038, 9'h00C, 9'h006, 9'h001};
          end
        end
        1: begin
          m_t++;
          if (m_t == dur) begin
            m_t = 0;
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
              m_mode = 2; m_idle = 0;
            end
          end
        end
        default: begin
          m_idle++;
          if (start || (AUTO && m_idle == RF)) begin
            m_mode = 1; m_t = 0; m_frame = 1'b1; m_idle = 0;
            m_q.delete();
            m_q.push_back(9'h080);
            m_q.push_back(9'h158);
            m_q.push_back(9'h13A);
            for (int i = 3; i >= 0; i--)
              m_q.push_back({1'b1, out_x[i*8 +: 8]});
            m_q.push_back(9'h120);
            m_q.push_back({1'b1, bx});
            m_q.push_back(9'h0C0);
            m_q.push_back(9'h159);
            m_q.push_back(9'h13A);
            for (int i = 3; i >= 0; i--)
              m_q.push_back({1'b1, out_y[i*8 +: 8]});
            m_q.push_back(9'h120);
            m_q.push_back({1'b1, by});
          end
        end
      endcase
    end
  end

  task automatic wait_ready(input int lim, output int c);
    for (int i = 0; i < lim; i++) begin
      if (ready) break;
      @(posedge clk); #1;
    end
    chk("ready_seen", ready, 1);
    c = cyc;
  endtask

  task automatic wait_done(input int lim, output int c);
    c = -1;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1;
      if (done) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) chk("done_seen", done, 1);
  endtask

  logic [8:0] exp_f [18];
  int rel, rc, s, dc, dc2, base, n;
  bit pe;

  initial begin
    exp_f = '{9'h080, 9'h158, 9'h13A, 9'h131, 9'h132, 9'h12E,
              9'h133, 9'h120, 9'h135, 9'h0C0, 9'h159, 9'h13A,
              9'h130, 9'h137, 9'h12E, 9'h138, 9'h120, 9'h132};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", lcd_data, 8'h00);
    chk("reset_e", lcd_e, 0);

    // power-up and init, start pulse during INIT is ignored
    cap_q.delete();
    base = done_cnt;
    rst_n = 1'b1;
    rel = cyc;
    repeat (20) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_ready(200, rc);
    chk("ready_latency", rc - rel, 42);
    chk("init_nbytes", cap_q.size(), 4);
    if (cap_q.size() == 4) begin
      chk("init_b0", cap_q[0], 9'h038);
      chk("init_b1", cap_q[1], 9'h00C);
      chk("init_b2", cap_q[2], 9'h006);
      chk("init_b3", cap_q[3], 9'h001);
    end
    repeat (20) @(posedge clk);
    #1;
    chk("init_start_ignored", done_cnt - base, 0);

    // directed frame with mid-frame input change and start at byte 9
    out_x = "12.3"; bx = "5";
    out_y = "07.8"; by = "2";
    cap_q.delete();
    base = done_cnt;
    start = 1'b1;
    s = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 out_x = "99.9";
    bx = "9";
    repeat (55) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(200, dc);
    chk("frame_latency", dc - s, 126);
    wait_ready(10, rc);
    chk("ready_after_done", rc - dc, 1);
    chk("one_done", done_cnt - base, 1);
    chk("frame_nbytes", cap_q.size(), 18);
    for (int i = 0; i < 18; i++)
      if (i < cap_q.size()) chk("frame_byte", cap_q[i], exp_f[i]);

    // start on the cycle ready rises
    out_x = "45.6";
    start = 1'b1;
    s = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(200, dc2);
    chk("b2b_latency", dc2 - s, 126);

    // randomized frames with start noise and changing inputs
    for (int it = 0; it < 8; it++) begin
      wait_ready(300, rc);
      repeat ($urandom_range(0, 20)) @(posedge clk);
      #1;
      out_x = {8'($urandom_range(32, 126)), 8'($urandom_range(32, 126)),
               8'($urandom_range(32, 126)), 8'($urandom_range(32, 126))};
      out_y = {8'($urandom_range(32, 126)), 8'($urandom_range(32, 126)),
               8'($urandom_range(32, 126)), 8'($urandom_range(32, 126))};
      bx = 8'($urandom_range(32, 126));
      by = 8'($urandom_range(32, 126));
      if (ready) begin
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
      for (int k = 0; k < 100; k++) begin
        start = ($urandom_range(0, 5) == 0);
        out_x = $urandom;
        bx = 8'($urandom);
        @(posedge clk); #1;
      end
      start = 1'b0;
    end

    // reset during EHI of byte 5
    wait_ready(300, rc);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; pe = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (lcd_e && !pe) n++;
      pe = lcd_e;
      if (n == 5) break;
      @(posedge clk); #1;
    end
    chk("byte5_reached", n, 5);
    rst_n = 1'b0;
    #1;
    chk("abort_e", lcd_e, 0);
    repeat (3) @(posedge clk);
    #1;
    cap_q.delete();
    rst_n = 1'b1;
    rel = cyc;
    wait_ready(200, rc);
    chk("rerun_latency", rc - rel, 42);
    chk("rerun_nbytes", cap_q.size(), 4);
    if (cap_q.size() > 0) chk("rerun_first", cap_q[0], 9'h038);

    // auto-refresh behaviour
    base = done_cnt;
`ifdef LCD_AUTO_REFRESH_EN
    wait_done(300, dc);
    chk("refresh_first", dc - rc, 175);
    wait_done(300, dc2);
    chk("refresh_period", dc2 - dc, 176);
`else
    repeat (400) @(posedge clk);
    #1;
    chk("no_refresh", done_cnt - base, 0);
    chk("still_ready", ready, 1);
`endif

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
